// File: rtl/registro_desplazable_conductual_pkg.sv
// Shared mode/fill encodings and default sizing for the shift-register family
// (behavioural and structural registers, stimulus generator, bench).
package registro_desplazable_conductual_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CW_DEF    = 5;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic FILL_LOGIC = 1'b0;
    localparam logic FILL_ROT   = 1'b1;

endpackage

// File: rtl/registro_desplazable_conductual_contador.sv
// contador_desplazamientos: modulo-WIDTH shift counter with increment,
// synchronous clear (clear wins) and asynchronous active-high reset.
module contador_desplazamientos #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/registro_desplazable_conductual.sv
// Behavioural universal shift register: hold / shift right / shift left / load,
// logical or rotate fill, registered serial-out and a shift counter.
module registro_desplazable_conductual
    import registro_desplazable_conductual_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CW    = CW_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       S,
    input  logic             MODO,
    input  logic [WIDTH-1:0] D,
    input  logic             S_IN,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic [CW-1:0]    CNT
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             s_out_q;
    logic             s_out_d;
    logic             shift_inc;
    logic             load_clr;
    logic             fill;

    // Next-state selection; undefined S falls into the default (hold) branch.
    always_comb begin
        q_d       = q_q;
        s_out_d   = s_out_q;
        shift_inc = 1'b0;
        load_clr  = 1'b0;
        fill      = S_IN;
        if (ENB) begin
            case (mode_e'(S))
                MODE_SHR: begin
                    fill      = (MODO == FILL_ROT) ? q_q[0] : S_IN;
                    q_d       = {fill, q_q[WIDTH-1:1]};
                    s_out_d   = q_q[0];
                    shift_inc = 1'b1;
                end
                MODE_SHL: begin
                    fill      = (MODO == FILL_ROT) ? q_q[WIDTH-1] : S_IN;
                    q_d       = {q_q[WIDTH-2:0], fill};
                    s_out_d   = q_q[WIDTH-1];
                    shift_inc = 1'b1;
                end
                MODE_LOAD: begin
                    q_d      = D;
                    s_out_d  = 1'b0;
                    load_clr = 1'b1;
                end
                default: begin
                    q_d     = q_q;
                    s_out_d = s_out_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q     <= '0;
            s_out_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            s_out_q <= s_out_d;
        end
    end

    contador_desplazamientos #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_contador (
        .clk (CLK),
        .rst (RESET),
        .inc (shift_inc),
        .clr (load_clr),
        .cnt (CNT)
    );

    assign Q     = q_q;
    assign S_OUT = s_out_q;

endmodule

// File: tb/tb_registro_desplazable_conductual.sv
// Bench for registro_desplazable_conductual: directed scenarios plus random
// traffic checked against an arithmetic reference model.
module tb_registro_desplazable_conductual;

    logic        CLK;
    logic        RESET;
    logic        ENB;
    logic [1:0]  S;
    logic        MODO;
    logic [31:0] D;
    logic        S_IN;
    logic [31:0] Q;
    logic        S_OUT;
    logic [4:0]  CNT;

    int tests;
    int fails;

    logic [31:0] m_q;
    logic        m_sout;
    int          m_cnt;

    registro_desplazable_conductual dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ENB   (ENB),
        .S     (S),
        .MODO  (MODO),
        .D     (D),
        .S_IN  (S_IN),
        .Q     (Q),
        .S_OUT (S_OUT),
        .CNT   (CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        m_q    = 32'd0;
        m_sout = 1'b0;
        m_cnt  = 0;
    endtask

    // Reference: shifts as multiply/divide by two plus an injected edge bit.
    task automatic model_step(input logic enb, input logic [1:0] s, input logic modo,
                              input logic [31:0] d, input logic sin);
        logic bit_out;
        logic fill_bit;
        if (!enb) return;
        if (s == 2'd1) begin
            bit_out  = m_q[0];
            fill_bit = modo ? bit_out : sin;
            m_q      = (m_q / 2) + (fill_bit ? 32'h8000_0000 : 32'd0);
            m_sout   = bit_out;
            m_cnt    = (m_cnt + 1) % 32;
        end else if (s == 2'd2) begin
            bit_out  = m_q[31];
            fill_bit = modo ? bit_out : sin;
            m_q      = (m_q * 2) + {31'd0, fill_bit};
            m_sout   = bit_out;
            m_cnt    = (m_cnt + 1) % 32;
        end else if (s == 2'd3) begin
            m_q    = d;
            m_sout = 1'b0;
            m_cnt  = 0;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic drive(input logic enb, input logic [1:0] s, input logic modo,
                         input logic [31:0] d, input logic sin);
        ENB  = enb;
        S    = s;
        MODO = modo;
        D    = d;
        S_IN = sin;
        @(posedge CLK);
        #1;
        model_step(enb, s, modo, d, sin);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        ENB = 1'b0; S = 2'd0; MODO = 1'b0; D = 32'd0; S_IN = 1'b0;
        model_reset();
        #3;
        tests++;
        if (Q !== 32'd0 || S_OUT !== 1'b0 || CNT !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: Q=%h S_OUT=%b CNT=%0d want 0/0/0", Q, S_OUT, CNT);
        end
        #4 RESET = 1'b0;
        drive(1'b1, 2'd3, 1'b0, 32'hFFFF_FFFF, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 32'd0, 1'b1);
        tests++;
        if (Q !== 32'hFFFF_FFFF || S_OUT !== 1'b1 || CNT !== 5'd1) begin
            fails++;
            $display("FAIL reset_preload: Q=%h S_OUT=%b CNT=%0d want ffffffff/1/1", Q, S_OUT, CNT);
        end
        #2 RESET = 1'b1;
        #1;
        tests++;
        if (Q !== 32'd0 || S_OUT !== 1'b0 || CNT !== 5'd0) begin
            fails++;
            $display("FAIL reset_async: Q=%h S_OUT=%b CNT=%0d want 0/0/0", Q, S_OUT, CNT);
        end
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_load_hold();
        drive(1'b1, 2'd3, 1'b1, 32'hA5A5_0F0F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd1, 1'b0, 32'd0, 1'b1);
            tests++;
            if (Q !== 32'hA5A5_0F0F || CNT !== 5'd0 || S_OUT !== 1'b0) begin
                fails++;
                $display("FAIL load_hold[%0d]: Q=%h CNT=%0d S_OUT=%b want a5a50f0f/0/0", i, Q, CNT, S_OUT);
            end
        end
        drive(1'b1, 2'd0, 1'b1, 32'd0, 1'b1);
        tests++;
        if (Q !== 32'hA5A5_0F0F || CNT !== 5'd0) begin
            fails++;
            $display("FAIL mode_hold: Q=%h CNT=%0d want a5a50f0f/0", Q, CNT);
        end
    endtask

    task automatic test_rotate_right();
        drive(1'b1, 2'd3, 1'b0, 32'h0000_0001, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            drive(1'b1, 2'd1, 1'b1, 32'd0, 1'b0);
            tests++;
            if (CNT !== 5'(i % 32) || Q !== m_q || S_OUT !== m_sout) begin
                fails++;
                $display("FAIL rotr[%0d]: Q=%h S_OUT=%b CNT=%0d want %h/%b/%0d",
                         i, Q, S_OUT, CNT, m_q, m_sout, i % 32);
            end
            if (i == 1) begin
                tests++;
                if (S_OUT !== 1'b1 || Q !== 32'h8000_0000) begin
                    fails++;
                    $display("FAIL rotr_first: Q=%h S_OUT=%b want 80000000/1", Q, S_OUT);
                end
            end
        end
        tests++;
        if (Q !== 32'h0000_0001 || CNT !== 5'd0) begin
            fails++;
            $display("FAIL rotr_full: Q=%h CNT=%0d want 00000001/0", Q, CNT);
        end
    endtask

    task automatic test_shift_logic();
        drive(1'b1, 2'd3, 1'b0, 32'h8000_0000, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 32'd0, 1'b0);
        tests++;
        if (Q !== 32'd0 || S_OUT !== 1'b1 || CNT !== 5'd1) begin
            fails++;
            $display("FAIL shl_msb_out: Q=%h S_OUT=%b CNT=%0d want 0/1/1", Q, S_OUT, CNT);
        end
        drive(1'b1, 2'd3, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 2'd1, 1'b0, 32'd0, 1'b1);
        tests++;
        if (Q !== 32'hF000_0000 || S_OUT !== 1'b0 || CNT !== 5'd4) begin
            fails++;
            $display("FAIL shr_fill_ones: Q=%h S_OUT=%b CNT=%0d want f0000000/0/4", Q, S_OUT, CNT);
        end
        drive(1'b1, 2'd3, 1'b1, 32'd0, 1'b1);
        tests++;
        if (Q !== 32'd0 || S_OUT !== 1'b0 || CNT !== 5'd0) begin
            fails++;
            $display("FAIL load_clears: Q=%h S_OUT=%b CNT=%0d want 0/0/0", Q, S_OUT, CNT);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'd3, 1'b0, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, 1'b1, 32'd0, 1'b0);
            tests++;
            if (Q !== m_q || S_OUT !== m_sout || CNT !== 5'(m_cnt)) begin
                fails++;
                $display("FAIL alt_dir[%0d]: Q=%h S_OUT=%b CNT=%0d want %h/%b/%0d",
                         i, Q, S_OUT, CNT, m_q, m_sout, m_cnt);
            end
        end
        tests++;
        if (Q !== 32'h1234_5678 || CNT !== 5'd10) begin
            fails++;
            $display("FAIL alt_dir_final: Q=%h CNT=%0d want 12345678/10", Q, CNT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                #2 RESET = 1'b1;
                #1 RESET = 1'b0;
                model_reset();
                tests++;
                if (Q !== 32'd0 || S_OUT !== 1'b0 || CNT !== 5'd0) begin
                    fails++;
                    $display("FAIL rand_reset: Q=%h S_OUT=%b CNT=%0d want 0/0/0", Q, S_OUT, CNT);
                end
            end
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom), 1'($urandom_range(0, 1)));
            tests++;
            if (Q !== m_q || S_OUT !== m_sout || CNT !== 5'(m_cnt)) begin
                fails++;
                $display("FAIL rand[%0d]: Q=%h S_OUT=%b CNT=%0d want %h/%b/%0d",
                         i, Q, S_OUT, CNT, m_q, m_sout, m_cnt);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_load_hold();
        test_rotate_right();
        test_shift_logic();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
